regfile_wb_scheduler: RTL and testbench

- Write-port scheduler and load scoreboard for the 32x32 register file in the pipelined RV32I core.
- Arbitrates the single register-file write port between:
  - ALU writeback from the W stage, which cannot be stalled.
  - Variable-latency load returns from data memory, buffered in a small FIFO.
- Tracks registers with an outstanding load and raises a decode stall on RAW or WAW hazards against them.
- Drives the register file's RegWrite, rd and WD3 inputs.

---
 rtl/regfile_wb_scheduler_if.sv | 49 ++++
 rtl/regfile_wb_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - signal bundle between decode, W stage, data memory and the register-file write port
//
// Groups the decode-issue handshake, ALU writeback, load-return stream and
// register-file write outputs of regfile_wb_scheduler.
//   master : the core/bench side (drives issue, ALU writeback, load returns)
//   slave  : the scheduler (drives stall_d, ld_ret_ready, RegWrite/rd/WD3, busy)
interface regfile_wb_scheduler_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic                 issue_valid;
    logic [AW-1:0]        issue_rs1;
    logic [AW-1:0]        issue_rs2;
    logic                 issue_use1;
    logic                 issue_use2;
    logic                 issue_is_load;
    logic [AW-1:0]        issue_rd;
    logic                 stall_d;

    logic                 alu_wb_valid;
    logic [AW-1:0]        alu_wb_rd;
    logic [DW-1:0]        alu_wb_data;

    logic                 ld_ret_valid;
    logic [AW-1:0]        ld_ret_rd;
    logic [DW-1:0]        ld_ret_data;
    logic                 ld_ret_ready;

    logic                 RegWrite;
    logic [AW-1:0]        rd;
    logic [DW-1:0]        WD3;
    logic [(1<<AW)-1:0]   busy;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use1, issue_use2,
               issue_is_load, issue_rd,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output ld_ret_valid, ld_ret_rd, ld_ret_data,
        input  stall_d, ld_ret_ready, RegWrite, rd, WD3, busy
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use1, issue_use2,
               issue_is_load, issue_rd,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  ld_ret_valid, ld_ret_rd, ld_ret_data,
        output stall_d, ld_ret_ready, RegWrite, rd, WD3, busy
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register-file write-port scheduler and load scoreboard
//
// Arbitrates the single register-file write port between the unstallable ALU
// writeback and a small FIFO of load returns, and stalls decode on RAW/WAW
// hazards against registers with an outstanding load.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : issue handshake + stall_d, ALU writeback, load-return
//                  stream + ld_ret_ready, registered RegWrite/rd/WD3, busy
//   stall_cnt    : (WB_STATS_EN only) saturating count of stalled cycles
//   conflict_cnt : (WB_STATS_EN only) saturating count of ALU-vs-FIFO conflicts
// Optional feature macro: WB_STATS_EN
module regfile_wb_scheduler #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LQ_DEPTH = 2,
    parameter int MAX_OUT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_scheduler_if.slave bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           conflict_cnt
`endif
);
    localparam int NREG = 1 << AW;
    localparam int PW   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW   = $clog2(LQ_DEPTH + 1);
    localparam int OW   = $clog2(MAX_OUT + 1);

    // Load-return FIFO storage and control
    logic [AW-1:0]   fifo_rd_q   [LQ_DEPTH];
    logic [DW-1:0]   fifo_data_q [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

    logic [OW-1:0]   out_cnt_q, out_cnt_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            reg_write_q, reg_write_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   wd3_q, wd3_d;

    logic            fifo_empty, fifo_full;
    logic            haz_a, haz_b, haz_c;
    logic            issue_fire, load_fire, ld_acc, pop;
    logic [AW-1:0]   head_rd;
    logic [DW-1:0]   head_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CW'(LQ_DEPTH));
    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];

    // Ready depends only on registered occupancy, never on ld_ret_valid,
    // so a full FIFO cannot take a return in the same cycle it pops.
    assign bus.ld_ret_ready = ~rst & ~fifo_full;

    assign haz_a = bus.issue_use1 & busy_q[bus.issue_rs1];
    assign haz_b = bus.issue_use2 & busy_q[bus.issue_rs2];
    assign haz_c = bus.issue_is_load &
                   (busy_q[bus.issue_rd] | (out_cnt_q == OW'(MAX_OUT)));

    assign bus.stall_d = rst | (bus.issue_valid & (haz_a | haz_b | haz_c));

    assign issue_fire = bus.issue_valid & ~bus.stall_d;
    assign load_fire  = issue_fire & bus.issue_is_load;
    assign ld_acc     = bus.ld_ret_valid & bus.ld_ret_ready;
    // The ALU cannot be held off, so the FIFO only drains on idle W-stage cycles.
    assign pop        = ~bus.alu_wb_valid & ~fifo_empty;

    // Write-port selection; rd/WD3 hold when nothing is selected.
    always_comb begin
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        wd3_d       = wd3_q;
        if (bus.alu_wb_valid) begin
            reg_write_d = (bus.alu_wb_rd != '0);
            rd_d        = bus.alu_wb_rd;
            wd3_d       = bus.alu_wb_data;
        end else if (!fifo_empty) begin
            reg_write_d = (head_rd != '0);
            rd_d        = head_rd;
            wd3_d       = head_data;
        end
    end

    // Scoreboard: the clear is applied first so a same-index set wins.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (load_fire) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        out_cnt_d  = out_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        case ({load_fire, pop})
            2'b10:   out_cnt_d = out_cnt_q + OW'(1);
            2'b01:   out_cnt_d = out_cnt_q - OW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
        case ({ld_acc, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (ld_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wd3_q       <= '0;
            busy_q      <= '0;
            out_cnt_q   <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wd3_q       <= wd3_d;
            busy_q      <= busy_d;
            out_cnt_q   <= out_cnt_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (ld_acc) begin
            fifo_rd_q[wr_ptr_q]   <= bus.ld_ret_rd;
            fifo_data_q[wr_ptr_q] <= bus.ld_ret_data;
        end
    end

    assign bus.RegWrite = reg_write_q;
    assign bus.rd       = rd_q;
    assign bus.WD3      = wd3_q;
    assign bus.busy     = busy_q;

`ifdef WB_STATS_EN
    logic [31:0] stall_cnt_q, conflict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (bus.stall_d && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bus.alu_wb_valid && !fifo_empty && (conflict_cnt_q != '1)) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int LQ_DEPTH = 2;
    localparam int MAX_OUT  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.DW(DW), .AW(AW)) bus ();

`ifdef WB_STATS_EN
    logic [31:0] stall_cnt, conflict_cnt;
`endif

    regfile_wb_scheduler #(
        .DW(DW), .AW(AW), .LQ_DEPTH(LQ_DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef WB_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .conflict_cnt(conflict_cnt)
`endif
    );

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int            due;
    } wr_t;

    typedef struct {
        int          cyc;
        logic        stall;
        logic        ready;
        logic [31:0] busy;
        logic [31:0] scnt;
        logic [31:0] ccnt;
    } st_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    wr_t           exp_q[$];
    st_t           st_q[$];
    ent_t          m_fifo[$];
    logic [AW-1:0] mem_q[$];
    logic [31:0]   m_busy = '0;
    int            m_out = 0;
    logic [31:0]   m_scnt = '0;
    logic [31:0]   m_ccnt = '0;
    int            cyc = 0;
    int            timeouts = 0;
    bit            last_acc = 1'b0;
    bit            done = 1'b0;

    int            tests = 0;
    int            fails = 0;
    int            cur_cyc = 0;
    st_t           mon_s;
    logic          mon_rw;

    // An ALU write to a register still awaiting its load is a hazard decode must prevent.
    always @(posedge clk) begin
        if (!rst && bus.alu_wb_valid) begin
            assert (bus.busy[bus.alu_wb_rd] == 1'b0)
                else $error("alu writeback to busy register x%0d", bus.alu_wb_rd);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cur_cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the expectations the driver queued.
    always @(negedge clk) begin
        #2;
        if (st_q.size() > 0) begin
            mon_s   = st_q.pop_front();
            cur_cyc = mon_s.cyc;
            chk("stall_d", 64'(bus.stall_d), 64'(mon_s.stall));
            chk("ld_ret_ready", 64'(bus.ld_ret_ready), 64'(mon_s.ready));
            chk("busy", 64'(bus.busy), 64'(mon_s.busy));
`ifdef WB_STATS_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(mon_s.scnt));
            chk("conflict_cnt", 64'(conflict_cnt), 64'(mon_s.ccnt));
`endif
            mon_rw = (exp_q.size() > 0) && (exp_q[0].due == mon_s.cyc);
            chk("RegWrite", 64'(bus.RegWrite), 64'(mon_rw));
            if (mon_rw) begin
                if (bus.RegWrite === 1'b1) begin
                    chk("rd", 64'(bus.rd), 64'(exp_q[0].rd));
                    chk("WD3", 64'(bus.WD3), 64'(exp_q[0].data));
                end
                void'(exp_q.pop_front());
            end
        end else if (done) begin
            chk("pending_writes", 64'(exp_q.size()), 64'd0);
            chk("wait_timeouts", 64'(timeouts), 64'd0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference model of one clock cycle, applied to the inputs currently driven.
    task automatic step();
        logic st, rdy, fire, acc;
        ent_t e;
        st_t  s;
        @(negedge clk);
        #1;
        if (rst) begin
            st  = 1'b1;
            rdy = 1'b0;
        end else begin
            st  = bus.issue_valid &
                  ((bus.issue_use1 & m_busy[bus.issue_rs1]) |
                   (bus.issue_use2 & m_busy[bus.issue_rs2]) |
                   (bus.issue_is_load & (m_busy[bus.issue_rd] | (m_out == MAX_OUT))));
            rdy = (m_fifo.size() < LQ_DEPTH);
        end
        s.cyc = cyc; s.stall = st; s.ready = rdy; s.busy = m_busy;
        s.scnt = m_scnt; s.ccnt = m_ccnt;
        st_q.push_back(s);
        last_acc = 1'b0;
        if (rst) begin
            m_fifo.delete();
            m_busy = '0;
            m_out  = 0;
            m_scnt = '0;
            m_ccnt = '0;
        end else begin
            fire = bus.issue_valid & ~st;
            acc  = bus.ld_ret_valid & rdy;
            if (st && m_scnt != 32'hFFFF_FFFF) m_scnt++;
            if (bus.alu_wb_valid && m_fifo.size() > 0 && m_ccnt != 32'hFFFF_FFFF) m_ccnt++;
            if (bus.alu_wb_valid) begin
                if (bus.alu_wb_rd != 0) exp_q.push_back('{bus.alu_wb_rd, bus.alu_wb_data, cyc + 1});
            end else if (m_fifo.size() > 0) begin
                e = m_fifo.pop_front();
                if (e.rd != 0) exp_q.push_back('{e.rd, e.data, cyc + 1});
                m_busy[e.rd] = 1'b0;
                m_out--;
            end
            if (fire && bus.issue_is_load) begin
                m_out++;
                if (bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
                mem_q.push_back(bus.issue_rd);
            end
            if (acc) m_fifo.push_back('{bus.ld_ret_rd, bus.ld_ret_data});
            last_acc = acc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input bit v, input int rs1, input int rs2, input bit u1,
                             input bit u2, input bit ld, input int rdi);
        bus.issue_valid   = v;
        bus.issue_rs1     = AW'(rs1);
        bus.issue_rs2     = AW'(rs2);
        bus.issue_use1    = u1;
        bus.issue_use2    = u2;
        bus.issue_is_load = ld;
        bus.issue_rd      = AW'(rdi);
    endtask

    task automatic set_alu(input bit v, input int r, input logic [DW-1:0] d);
        bus.alu_wb_valid = v;
        bus.alu_wb_rd    = AW'(r);
        bus.alu_wb_data  = d;
    endtask

    // Memory side: holds a presented return until accepted, returns loads in issue order.
    task automatic mem_drive(input int pct);
        if (bus.ld_ret_valid && !last_acc) return;
        if (mem_q.size() > 0 && $urandom_range(99) < pct) begin
            bus.ld_ret_valid = 1'b1;
            bus.ld_ret_rd    = mem_q.pop_front();
            bus.ld_ret_data  = $urandom();
        end else begin
            bus.ld_ret_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_alu(0, 0, '0);
        for (int i = 0; i < 60; i++) begin
            mem_drive(100);
            step();
            if ((!bus.ld_ret_valid || last_acc) && mem_q.size() == 0 && m_fifo.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeouts++;
        bus.ld_ret_valid = 1'b0;
        step();
        step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            set_issue($urandom_range(1), $urandom_range(31), $urandom_range(31),
                      $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(31));
            set_alu($urandom_range(1), $urandom_range(31), $urandom());
            bus.ld_ret_valid = 1'(($urandom_range(1)));
            bus.ld_ret_rd    = AW'($urandom_range(31));
            bus.ld_ret_data  = $urandom();
            step();
        end
        rst = 1'b0;
        mem_q.delete();
        bus.ld_ret_valid = 1'b0;
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_alu(0, 0, '0);
    endtask

    initial begin
        int r;
        rst = 1'b1;
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_alu(0, 0, '0);
        bus.ld_ret_valid = 1'b0;
        bus.ld_ret_rd    = '0;
        bus.ld_ret_data  = '0;

        // Reset held for two cycles with random inputs, then idle after release.
        do_reset(2);
        step();
        step();

        // RAW stall on x5 until its load returns and is written.
        set_issue(1, 0, 0, 0, 0, 1, 5);
        step();
        set_issue(1, 5, 0, 1, 0, 0, 0);
        step();
        bus.ld_ret_valid = 1'b1;
        bus.ld_ret_rd    = mem_q.pop_front();
        bus.ld_ret_data  = 32'hDEAD_BEEF;
        step();
        bus.ld_ret_valid = 1'b0;
        repeat (3) step();
        drain();

        // x7 return buffered behind three ALU writes to x3.
        set_issue(1, 0, 0, 0, 0, 1, 7);
        step();
        set_issue(0, 0, 0, 0, 0, 0, 0);
        bus.ld_ret_valid = 1'b1;
        bus.ld_ret_rd    = mem_q.pop_front();
        bus.ld_ret_data  = $urandom();
        step();
        bus.ld_ret_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_alu(1, 3, 32'(8'h11 * (i + 1)));
            step();
        end
        drain();

        // Outstanding limit: four loads in flight, a fifth waits for a pop.
        for (int i = 1; i <= 4; i++) begin
            set_issue(1, 0, 0, 0, 0, 1, i);
            step();
        end
        set_issue(1, 0, 0, 0, 0, 1, 6);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            mem_drive(100);
            step();
        end
        drain();

        // Loads and ALU writes to x0 never mark busy or write.
        set_issue(1, 0, 0, 0, 0, 1, 0);
        step();
        set_issue(0, 0, 0, 0, 0, 0, 0);
        bus.ld_ret_valid = 1'b1;
        bus.ld_ret_rd    = mem_q.pop_front();
        bus.ld_ret_data  = 32'h0000_1234;
        set_alu(1, 0, $urandom());
        step();
        bus.ld_ret_valid = 1'b0;
        set_alu(0, 0, '0);
        drain();

        // FIFO fills behind continuous ALU writes; the third return must wait.
        for (int i = 8; i <= 10; i++) begin
            set_issue(1, 0, 0, 0, 0, 1, i);
            step();
        end
        set_issue(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            set_alu(1, 3, $urandom());
            mem_drive(100);
            step();
        end
        drain();

        // Randomized traffic with occasional mid-operation resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299) == 0) begin
                do_reset($urandom_range(1, 2));
            end
            set_issue($urandom_range(99) < 60, $urandom_range(31), $urandom_range(31),
                      $urandom_range(1), $urandom_range(1), $urandom_range(99) < 35,
                      $urandom_range(31));
            r = $urandom_range(31);
            if (m_busy[r]) r = 0;
            set_alu($urandom_range(99) < 40, r, $urandom());
            mem_drive(50);
            step();
        end
        drain();
        done = 1'b1;
    end
endmodule
